instruction_fetch_unit: RTL and testbench

//  IF-stage producer for the IF/ID pipeline register. Owns the fetch PC and issues word reads to

---
 rtl/instruction_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, keeps one imem read in flight, feeds IF/ID through a slot plus skid.
// Optional misaligned-redirect trap: define IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
`ifdef IFU_MISALIGN_TRAP_EN
    output logic        misaligned_IF,
`endif
    output logic [31:0] pc0_IF,
    output logic [31:0] pc4_IF,
    output logic [31:0] instruction_IF,
    output logic        invalid_IF
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
`ifdef IFU_MISALIGN_TRAP_EN
        S_HALT,
`endif
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        slot_v_q, slot_v_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_ins_q, slot_ins_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_ins_q, skid_ins_d;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic        consume;
    logic        accept;
    logic [31:0] tgt;

    assign imem_req       = rst_n && (state_q == S_FETCH);
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req && imem_ready;
    assign consume        = slot_v_q && !stall;
    assign tgt            = redirect_pc & ~32'h3;
    assign pc0_IF         = slot_pc_q;
    assign pc4_IF         = slot_pc_q + 32'd4;
    assign instruction_IF = slot_v_q ? slot_ins_q : NOP;
    assign invalid_IF     = !slot_v_q;
`ifdef IFU_MISALIGN_TRAP_EN
    assign misaligned_IF  = mis_q;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        slot_v_d   = slot_v_q;
        slot_pc_d  = slot_pc_q;
        slot_ins_d = slot_ins_q;
        skid_v_d   = skid_v_q;
        skid_pc_d  = skid_pc_q;
        skid_ins_d = skid_ins_q;
`ifdef IFU_MISALIGN_TRAP_EN
        mis_d      = mis_q;
`endif
        if (redirect) begin
            slot_v_d   = 1'b0;
            skid_v_d   = 1'b0;
            fetch_pc_d = tgt;
            // a request still in flight must have its response swallowed
            if (((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid)
                || (state_q == S_FETCH && accept))
                state_d = S_DRAIN;
            else
                state_d = S_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
            mis_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                slot_v_d   = 1'b1;
                slot_pc_d  = redirect_pc;
                slot_ins_d = NOP;
                mis_d      = 1'b1;
                state_d    = S_HALT;
            end
`endif
        end else begin
            if (consume) begin
                slot_v_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                mis_d    = 1'b0;
`endif
            end
            unique case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        req_pc_d = fetch_pc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        fetch_pc_d = req_pc_q + 32'd4;
                        if (!slot_v_q || consume) begin
                            slot_v_d   = 1'b1;
                            slot_pc_d  = req_pc_q;
                            slot_ins_d = imem_rdata;
                            state_d    = S_FETCH;
                        end else begin
                            skid_v_d   = 1'b1;
                            skid_pc_d  = req_pc_q;
                            skid_ins_d = imem_rdata;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        slot_v_d   = skid_v_q;
                        slot_pc_d  = skid_pc_q;
                        slot_ins_d = skid_ins_q;
                        skid_v_d   = 1'b0;
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid)
                        state_d = S_FETCH;
                end
`ifdef IFU_MISALIGN_TRAP_EN
                S_HALT: state_d = S_HALT;
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            slot_v_q   <= 1'b0;
            slot_pc_q  <= RESET_PC;
            slot_ins_q <= NOP;
            skid_v_q   <= 1'b0;
            skid_pc_q  <= RESET_PC;
            skid_ins_q <= NOP;
`ifdef IFU_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            slot_v_q   <= slot_v_d;
            slot_pc_q  <= slot_pc_d;
            slot_ins_q <= slot_ins_d;
            skid_v_q   <= skid_v_d;
            skid_pc_q  <= skid_pc_d;
            skid_ins_q <= skid_ins_d;
`ifdef IFU_MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model plus in-order scoreboard of fetched PCs.
// Build with IFU_MISALIGN_TRAP_EN defined to exercise the misaligned trap.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc0_IF, pc4_IF, instruction_IF;
    logic        invalid_IF;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        misaligned_IF;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
`ifdef IFU_MISALIGN_TRAP_EN
        .misaligned_IF  (misaligned_IF),
`endif
        .pc0_IF         (pc0_IF),
        .pc4_IF         (pc4_IF),
        .instruction_IF (instruction_IF),
        .invalid_IF     (invalid_IF)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    bit          lat_rand = 0;
    int          rdy_mode = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] nxt_addr = RPC;
    logic [31:0] exp_q[$];
    bit          acc_now, cons_now;
    int          cons_total = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic pre();
        logic [31:0] e;
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(paddr);
                pend        = 0;
            end
        end
        case (rdy_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ($urandom_range(0, 3) != 0);
            default: imem_ready = 1'b0;
        endcase
        #1;
        acc_now = imem_req && imem_ready;
        if (acc_now) begin
            chk("one_outstanding", 32'(pend), 32'd0);
            chk("acc_addr", imem_addr, nxt_addr);
            exp_q.push_back(nxt_addr);
            nxt_addr = nxt_addr + 32'd4;
            pend  = 1;
            cnt   = lat_rand ? $urandom_range(1, 3) : lat;
            paddr = imem_addr;
        end
        cons_now = rst_n && !stall && !redirect && !invalid_IF;
        if (cons_now) begin
            cons_total++;
            if (exp_q.size() == 0) begin
                chk("sb_level", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pc0", pc0_IF, e);
                chk("pc4", pc4_IF, e + 32'd4);
                chk("instr", instruction_IF, memf(e));
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            nxt_addr = RPC;
        end else if (redirect) begin
            exp_q.delete();
            nxt_addr = redirect_pc & ~32'h3;
`ifdef IFU_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00)
                nxt_addr = 32'hDEAD_BEE0;
`endif
        end
    endtask

    task automatic post();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            pre();
            post();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_cons(input string tag, input logic [31:0] pc);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (cons_now) begin
                found = 1;
                chk(tag, pc0_IF, pc);
            end
            post();
        end
        chk({tag, "_timeout"}, 32'(found), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        cyc(1);
        pre();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_inv", 32'(invalid_IF), 32'd1);
        chk("rst_instr", instruction_IF, NOP);
        chk("rst_pc0", pc0_IF, RPC);
        chk("rst_pc4", pc4_IF, RPC + 32'd4);
        chk("rst_addr", imem_addr, RPC);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("rst_mis", 32'(misaligned_IF), 32'd0);
`endif
        post();
        rst_n = 1'b1;

        // 1: streaming, 1-cycle memory
        for (int c = 0; c < 8; c++) begin
            pre();
            chk("t1_req", 32'(imem_req), 32'(c % 2 == 0));
            chk("t1_inv", 32'(invalid_IF), 32'(!(c >= 2 && c % 2 == 0)));
            post();
        end

        // 2: stall fills skid, then drains in order
        do_reset();
        for (int c = 0; c < 10; c++) begin
            stall = (c >= 2 && c <= 5);
            pre();
            if (c == 4 || c == 5) begin
                chk("t2_hold_req", 32'(imem_req), 32'd0);
                chk("t2_hold_pc", pc0_IF, RPC);
            end
            if (c == 6) chk("t2_first", pc0_IF, RPC);
            if (c == 7) begin
                chk("t2_second", pc0_IF, RPC + 32'd4);
                chk("t2_inv", 32'(invalid_IF), 32'd0);
            end
            post();
        end
        stall = 1'b0;

        // 3: redirect during WAIT, 3-cycle memory
        lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (acc_now && imem_addr == RPC + 32'd4) found = 1;
            post();
        end
        chk("t3_acc_timeout", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h200;
        pre();
        chk("t3_in_wait", 32'(imem_req), 32'd0);
        post();
        redirect = 1'b0;
        wait_cons("t3_first", 32'h200);

        // 4: redirect overrides stall with slot valid
        lat = 1;
        stall = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (!invalid_IF) found = 1;
            post();
        end
        chk("t4_valid_timeout", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h300;
        cyc(1);
        redirect = 1'b0;
        pre();
        chk("t4_inv", 32'(invalid_IF), 32'd1);
        chk("t4_instr", instruction_IF, NOP);
        post();
        stall = 1'b0;
        wait_cons("t4_resume", 32'h300);

        // 5: reset while a request is outstanding
        lat = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (acc_now) found = 1;
            post();
        end
        chk("t5_acc_timeout", 32'(found), 32'd1);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pre();
            chk("t5_rst_req", 32'(imem_req), 32'd0);
            post();
        end
        rst_n = 1'b1;
        pre();
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, RPC);
        chk("t5_inv", 32'(invalid_IF), 32'd1);
        post();
        lat = 1;
        cyc(8);

`ifdef IFU_MISALIGN_TRAP_EN
        // 6: misaligned redirect halts fetch until next redirect
        do_reset();
        rdy_mode = 2;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h202;
        cyc(1);
        redirect = 1'b0; rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            pre();
            chk("t6_mis", 32'(misaligned_IF), 32'd1);
            chk("t6_pc0", pc0_IF, 32'h202);
            chk("t6_inv", 32'(invalid_IF), 32'd0);
            chk("t6_req", 32'(imem_req), 32'd0);
            chk("t6_instr", instruction_IF, NOP);
            post();
        end
        redirect = 1'b1; redirect_pc = 32'h300;
        cyc(1);
        redirect = 1'b0; stall = 1'b0;
        pre();
        chk("t6_mis_clr", 32'(misaligned_IF), 32'd0);
        chk("t6_resume_addr", imem_addr, 32'h300);
        post();
        wait_cons("t6_resume", 32'h300);
`else
        // 6: low redirect bits are masked off
        redirect = 1'b1; redirect_pc = 32'h246;
        cyc(1);
        redirect = 1'b0;
        wait_cons("t6_mask", 32'h244);
`endif

        // 7: PC wraps modulo 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc(1);
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            pre();
            if (cons_now && pc0_IF == 32'hFFFF_FFFC) begin
                found = 1;
                chk("t7_pc4_wrap", pc4_IF, 32'h0);
            end
            post();
        end
        chk("t7_timeout", 32'(found), 32'd1);

        // random traffic: stalls, backpressure, variable latency, redirects
        rdy_mode = 1;
        lat_rand = 1;
        for (int i = 0; i < 800; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 49) == 0);
            redirect_pc = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            cyc(1);
        end
        stall = 1'b0; redirect = 1'b0; rdy_mode = 0; lat_rand = 0;
        cyc(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
